// File: rtl/vga_text_render_pkg.sv
// Shared constants and types for the VGA text overlay.
//   - 640x480 timing constants (active/total, both axes)
//   - glyph code names for the 16-entry 3x5 font
//   - text-slot entry struct, fetch FSM state enum
//   - glyph_row(): extracts one 3-pixel row from a packed 16-bit glyph
package vga_text_render_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  typedef enum logic [3:0] {
    G_0, G_1, G_2, G_3, G_4, G_5, G_6, G_7, G_8, G_9,
    G_PLUS, G_MINUS, G_MUL, G_DIV, G_EQ, G_BANG
  } glyph_t;

  typedef struct packed {
    logic       vis;
    logic [3:0] code;
  } txt_ent_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH_HI, S_FETCH_LO} fetch_st_t;

  // Pixel (r,c) lives at bit 15-(3r+c); result bit 2 is column 0.
  function automatic logic [2:0] glyph_row(input logic [15:0] g, input logic [2:0] r);
    logic [15:0] sh;
    sh = g >> (13 - 3 * int'(r));
    return sh[2:0];
  endfunction

endpackage

// File: rtl/vga_textbuf.sv
// Text line register file: NCHARS entries of {visible, code}.
//   clk, reset : clock, synchronous active-high reset (clears all slots)
//   we, wa, wd : write port
//   ridx, rdat : asynchronous read port
module vga_textbuf
  import vga_text_render_pkg::*;
#(
  parameter int NCHARS = 8,
  localparam int SW    = $clog2(NCHARS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [SW-1:0] wa,
  input  txt_ent_t      wd,
  input  logic [SW-1:0] ridx,
  output txt_ent_t      rdat
);

  txt_ent_t [NCHARS-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  assign rdat = mem_q[ridx];

endmodule

// File: rtl/vga_text_render.sv
// Text overlay renderer between the sync generator and the glyph ROM.
//   clk, reset        : pixel clock, synchronous active-high reset
//   hcount, vcount    : current pixel position; video_on qualifies active area
//   hs_in, vs_in      : syncs, re-emitted as hs_out/vs_out one cycle later
//   we, wa, wd        : text-slot write port, wd = {visible, code}
//   ra, rd            : glyph ROM address / combinational data
//   rgb               : registered pixel colour (1-cycle latency)
//   busy              : glyph fetch in progress
// During each hblank the next line's glyph rows are fetched (two ROM bytes per
// slot) into linebuf, so linebuf never changes while pixels are being drawn.
module vga_text_render
  import vga_text_render_pkg::*;
#(
  parameter int         NCHARS     = 8,
  parameter int         X0         = 256,
  parameter int         Y0         = 200,
  parameter int         SCALE_LOG2 = 2,
  parameter logic [2:0] FG         = 3'b111,
  parameter logic [2:0] BG         = 3'b000,
  localparam int        SW         = $clog2(NCHARS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    hcount,
  input  logic [9:0]    vcount,
  input  logic          video_on,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          we,
  input  logic [SW-1:0] wa,
  input  logic [4:0]    wd,
  output logic [4:0]    ra,
  input  logic [7:0]    rd,
  output logic          hs_out,
  output logic          vs_out,
  output logic [2:0]    rgb,
  output logic          busy
);

  fetch_st_t                state_q;
  logic [SW-1:0]            slot_q, rd_idx;
  logic [4:0]               ra_q;
  logic [7:0]               hi_q;
  logic                     vis_q, line_vis_q, line_vis_d;
  logic [2:0]               grow_q, grow_d;
  logic [NCHARS-1:0][2:0]   linebuf_q;
  txt_ent_t                 ent;
  logic [9:0]               ny, dy;

  vga_textbuf #(.NCHARS(NCHARS)) u_textbuf (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .wa   (wa),
    .wd   (txt_ent_t'(wd)),
    .ridx (rd_idx),
    .rdat (ent)
  );

  // Single read port: IDLE preloads slot 0, FETCH_HI latches the current
  // slot's visible bit and low-byte address, FETCH_LO looks one slot ahead.
  always_comb begin
    rd_idx = '0;
    case (state_q)
      S_FETCH_HI: rd_idx = slot_q;
      S_FETCH_LO: rd_idx = slot_q + SW'(1);
      default:    rd_idx = '0;
    endcase
  end

  // Target line and its glyph row; the subtraction wraps so lines above Y0
  // fail the unsigned window compare.
  always_comb begin
    ny         = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    dy         = ny - 10'(Y0);
    line_vis_d = dy < 10'(5 << SCALE_LOG2);
    grow_d     = 3'(dy >> SCALE_LOG2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      ra_q       <= '0;
      hi_q       <= '0;
      vis_q      <= 1'b0;
      line_vis_q <= 1'b0;
      grow_q     <= '0;
      linebuf_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (hcount == 10'(H_ACTIVE)) begin
          state_q    <= S_FETCH_HI;
          slot_q     <= '0;
          ra_q       <= {ent.code, 1'b0};
          line_vis_q <= line_vis_d;
          grow_q     <= grow_d;
        end
        S_FETCH_HI: begin
          hi_q    <= rd;
          vis_q   <= ent.vis;
          ra_q    <= {ent.code, 1'b1};
          state_q <= S_FETCH_LO;
        end
        S_FETCH_LO: begin
          linebuf_q[slot_q] <= (vis_q && line_vis_q) ? glyph_row({hi_q, rd}, grow_q) : 3'b000;
          if (slot_q == SW'(NCHARS - 1)) begin
            state_q <= S_IDLE;
          end else begin
            slot_q  <= slot_q + SW'(1);
            ra_q    <= {ent.code, 1'b0};
            state_q <= S_FETCH_HI;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Render: each glyph cell is 4 columns wide, column 3 being the gap.
  logic [9:0] rel_x, gx, s;
  logic [1:0] c;
  logic [2:0] lb_row, rgb_d, rgb_q;
  logic       on, hs_q, vs_q;

  always_comb begin
    rel_x  = hcount - 10'(X0);
    gx     = rel_x >> SCALE_LOG2;
    s      = gx >> 2;
    c      = gx[1:0];
    lb_row = linebuf_q[s[SW-1:0]];
    on     = video_on && (hcount >= 10'(X0)) && (s < 10'(NCHARS)) &&
             (c != 2'd3) && lb_row[2'd2 - c];
    rgb_d  = !video_on ? 3'b000 : (on ? FG : BG);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_in;
      vs_q  <= vs_in;
    end
  end

  assign ra     = ra_q;
  assign rgb    = rgb_q;
  assign hs_out = hs_q;
  assign vs_out = vs_q;
  assign busy   = (state_q != S_IDLE);

endmodule
